// File: rtl/adder_subtractor_checker_if.sv
// rtl/adder_subtractor_checker_if.sv - operand/result bus between the checker and the 4-bit adder/subtractor
interface adder_subtractor_checker_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       C0;
    logic [3:0] S;
    logic       Carry;
    logic       V;

    modport master (output A, output B, output C0, input S, input Carry, input V);
    modport slave  (input A, input B, input C0, output S, output Carry, output V);
endinterface

// File: rtl/adder_subtractor_checker.sv
// rtl/adder_subtractor_checker.sv - exhaustive 512-vector sweep and golden check of a 4-bit adder/subtractor
// Optional feature macro: CHECKER_STOP_ON_FAIL_EN (halt on the first mismatching vector).
module adder_subtractor_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    adder_subtractor_checker_if.master  dut,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [9:0]                  err_count,
    output logic [8:0]                  first_fail_vec
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [2:0] state;
    logic [8:0] vec;
    logic [3:0] settle_cnt;

    logic [4:0] gold_sum;
    logic       gold_v;
    logic       mismatch;

    // Golden model works on the registered operands, which equal vec while in CHECK.
    always_comb begin
        gold_sum = 5'd0;
        gold_v   = 1'b0;
        if (dut.C0) begin
            gold_sum = {1'b0, dut.A} + {1'b0, ~dut.B} + 5'd1;
            gold_v   = (dut.A[3] != dut.B[3]) & (gold_sum[3] != dut.A[3]);
        end else begin
            gold_sum = {1'b0, dut.A} + {1'b0, dut.B};
            gold_v   = (dut.A[3] == dut.B[3]) & (gold_sum[3] != dut.A[3]);
        end
        mismatch = (dut.S != gold_sum[3:0]) || (dut.Carry != gold_sum[4]) || (dut.V != gold_v);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            vec            <= 9'd0;
            settle_cnt     <= 4'd0;
            err_count      <= 10'd0;
            first_fail_vec <= 9'd0;
            dut.A          <= 4'd0;
            dut.B          <= 4'd0;
            dut.C0         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec            <= 9'd0;
                        err_count      <= 10'd0;
                        first_fail_vec <= 9'd0;
                        state          <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    {dut.C0, dut.A, dut.B} <= vec;
                    settle_cnt             <= 4'd0;
                    state                  <= S_WAIT;
                end
                S_WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 10'd1;
                        if (err_count == 10'd0) begin
                            first_fail_vec <= vec;
                        end
                    end
`ifdef CHECKER_STOP_ON_FAIL_EN
                    if (mismatch || vec == 9'd511) begin
`else
                    if (vec == 9'd511) begin
`endif
                        state <= S_DONE;
                    end else begin
                        vec   <= vec + 9'd1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 10'd0);

endmodule

// File: tb/tb_adder_subtractor_checker.sv
// tb/tb_adder_subtractor_checker.sv - scoreboard bench driving the checker against a fault-injectable adder/subtractor model
module tb_adder_subtractor_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [9:0] err_count;
    logic [8:0] first_fail_vec;

    adder_subtractor_checker_if bus ();

    adder_subtractor_checker #(.SETTLE_CYCLES(2)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .dut            (bus.master),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 0 correct, 1 S[0] stuck-at-0, 2 V inverted, 3 wrong only at the two spot vectors,
    // 4 hand-written correct results forced at the two spot vectors
    int mode = 0;
    logic [4:0] r;
    always_comb begin
        r = bus.C0 ? ({1'b0, bus.A} + {1'b0, ~bus.B} + 5'd1) : ({1'b0, bus.A} + {1'b0, bus.B});
        bus.S     = r[3:0];
        bus.Carry = r[4];
        bus.V     = bus.C0 ? ((bus.A[3] != bus.B[3]) & (r[3] != bus.A[3]))
                           : ((bus.A[3] == bus.B[3]) & (r[3] != bus.A[3]));
        if (mode == 1) bus.S[0] = 1'b0;
        if (mode == 2) bus.V = ~bus.V;
        if ({bus.C0, bus.A, bus.B} == 9'h071) begin
            if (mode == 3) {bus.S, bus.Carry, bus.V} = {4'b1000, 1'b0, 1'b0};
            if (mode == 4) {bus.S, bus.Carry, bus.V} = {4'b1000, 1'b0, 1'b1};
        end
        if ({bus.C0, bus.A, bus.B} == 9'h135) begin
            if (mode == 3) {bus.S, bus.Carry, bus.V} = {4'b1110, 1'b1, 1'b0};
            if (mode == 4) {bus.S, bus.Carry, bus.V} = {4'b1110, 1'b0, 1'b0};
        end
    end

    typedef struct {
        int lat;
        int err;
        int ffv;
        int pas;
        int vec;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   start_cyc = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each rising edge of done retires one scoreboard entry.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc - start_cyc - 1, e.lat);
                chk("err_count", int'(err_count), e.err);
                chk("first_fail_vec", int'(first_fail_vec), e.ffv);
                chk("pass", int'(pass), e.pas);
                chk("final_vec", int'({bus.C0, bus.A, bus.B}), e.vec);
            end
        end
        done_prev = done;
    end

    task automatic run_sweep(input int m, input int lat, input int err, input int ffv,
                             input int pas, input int vec, input bit busy_pulse);
        exp_t e;
        bit   seen;
        e = '{lat, err, ffv, pas, vec};
        sb.push_back(e);
        mode = m;
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = busy_pulse && (i == 500);
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_ffv"}, int'(first_fail_vec), 0);
        chk({tag, "_abc0"}, int'({bus.C0, bus.A, bus.B}), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("reset");

        run_sweep(0, 2048, 0, 0, 1, 9'h1FF, 1'b0);
        run_sweep(4, 2048, 0, 0, 1, 9'h1FF, 1'b0);
`ifdef CHECKER_STOP_ON_FAIL_EN
        run_sweep(1, 8, 1, 1, 0, 9'h001, 1'b0);
        run_sweep(2, 4, 1, 0, 0, 9'h000, 1'b0);
        run_sweep(3, 456, 1, 9'h071, 0, 9'h071, 1'b0);
`else
        run_sweep(1, 2048, 256, 1, 0, 9'h1FF, 1'b0);
        run_sweep(2, 2048, 512, 0, 0, 9'h1FF, 1'b0);
        run_sweep(3, 2048, 2, 9'h071, 0, 9'h1FF, 1'b0);
`endif

        // Abort a clean sweep at cycle 1000 with reset.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (998) @(negedge clk);
        chk("midsweep_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midreset");
        reset = 1'b0;
        @(negedge clk);

        run_sweep(0, 2048, 0, 0, 1, 9'h1FF, 1'b1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
